// File: rtl/mult_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiplier.
interface mult_unit_if;
  logic        start_i;
  logic [1:0]  mult_type_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  modport slave (
    input  start_i, mult_type_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    output ready_o, busy_o, done_o, result_o, rd_addr_o
  );

  modport master (
    output start_i, mult_type_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    input  ready_o, busy_o, done_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), BITS_PER_CYCLE multiplier bits per step.
// Optional MULT_ZERO_SKIP_EN: zero operands finish in one step after acceptance.
module mult_unit #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic     clk,
  input  logic     rst,
  mult_unit_if.slave bus
);
  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] T_LOW = 2'b00;
  localparam logic [1:0] T_SS  = 2'b01;
  localparam logic [1:0] T_SU  = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [1:0]    type_q, type_d;
  logic [4:0]    rd_q, rd_d;
  logic [4:0]    rd_out_q, rd_out_d;
  logic [31:0]   mcand_q, mcand_d;
  logic [31:0]   mplier_q, mplier_d;
  logic [31:0]   result_q, result_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;

  logic          sign_a, sign_b;
  logic [31:0]   mag_a, mag_b;
  logic [6:0]    shamt;
  logic [63:0]   pp, prod;

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;

    sign_a = bus.rs1_data_i[31] & ((bus.mult_type_i == T_SS) | (bus.mult_type_i == T_SU));
    sign_b = bus.rs2_data_i[31] & (bus.mult_type_i == T_SS);
    mag_a  = sign_a ? (32'd0 - bus.rs1_data_i) : bus.rs1_data_i;
    mag_b  = sign_b ? (32'd0 - bus.rs2_data_i) : bus.rs2_data_i;

    shamt = 7'(cnt_q) * 7'(BITS_PER_CYCLE);
    pp    = (64'(mcand_q) * 64'(mplier_q[BITS_PER_CYCLE-1:0])) << shamt;
    prod  = neg_q ? (64'd0 - acc_q) : acc_q;

    // Flush leaves result/rd untouched so an aborted op is invisible downstream.
    if (bus.flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            state_d  = S_CALC;
            type_d   = bus.mult_type_i;
            rd_d     = bus.rd_addr_i;
            mcand_d  = mag_a;
            mplier_d = mag_b;
            neg_d    = sign_a ^ sign_b;
            acc_d    = 64'd0;
            cnt_d    = '0;
`ifdef MULT_ZERO_SKIP_EN
            // Jump straight to the finalize step; the cleared accumulator yields 0.
            if ((bus.rs1_data_i == 32'd0) || (bus.rs2_data_i == 32'd0))
              cnt_d = CW'(N);
`endif
          end
        end
        S_CALC: begin
          if (cnt_q == CW'(N)) begin
            state_d  = S_DONE;
            result_d = (type_q == T_LOW) ? prod[31:0] : prod[63:32];
            rd_out_d = rd_q;
          end else begin
            acc_d    = acc_q + pp;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + CW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      type_q   <= 2'b00;
      rd_q     <= 5'd0;
      rd_out_q <= 5'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      result_q <= 32'd0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= 64'd0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.ready_o   = (state_q == S_IDLE);
  assign bus.busy_o    = (state_q == S_CALC) | (state_q == S_DONE);
  assign bus.done_o    = (state_q == S_DONE);
  assign bus.result_o  = result_q;
  assign bus.rd_addr_o = rd_out_q;
endmodule
